clint_trap_ctrl: RTL

//  Core-local trap sequencer feeding the CSR file. Detects sync traps (ecall/ebreak), mret and level

---
 rtl/clint_trap_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/clint_trap_ctrl.sv
// Core-local trap sequencer: ecall/ebreak/mret/async interrupt -> CSR write strobes -> fetch redirect.
// Optional macro CLINT_VECTORED_EN enables vectored async trap targets when mtvec[0]=1.
module clint_trap_ctrl #(
    parameter int unsigned DW      = 16,
    parameter int unsigned INT_NUM = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      ID_pc,
    input  logic               ID_ecall,
    input  logic               ID_ebreak,
    input  logic               ID_mret,
    input  logic               EX_jump,
    input  logic [DW-1:0]      EX_jump_addr,
    input  logic               EX_csr_we,
    input  logic [INT_NUM-1:0] int_req,
    input  logic [DW-1:0]      csr_mtvec,
    input  logic [DW-1:0]      csr_mepc,
    input  logic [DW-1:0]      csr_mstatus,
    input  logic               global_int_en,
    output logic [2:0]         int_we,
    output logic [DW-1:0]      int_mepc,
    output logic [DW-1:0]      int_mcause,
    output logic [DW-1:0]      int_mstatus,
    output logic               int_hold,
    output logic               int_jump,
    output logic [DW-1:0]      int_jump_addr
);

    localparam logic [DW-1:0] CAUSE_INT    = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] CAUSE_ECALL  = DW'(11);
    localparam logic [DW-1:0] CAUSE_EBREAK = DW'(3);

    typedef enum logic [1:0] {IDLE, WRITE, JUMP} state_t;

    state_t        state;
    logic          trap_q;
    logic [DW-1:0] cause_q;
    logic [DW-1:0] epc_q;
`ifdef CLINT_VECTORED_EN
    logic          async_q;
`endif

    logic          async_ev;
    logic          event_c;
    logic [DW-1:0] async_cause;
    logic [DW-1:0] trap_base;
    logic [DW-1:0] trap_addr;
    logic [DW-1:0] mstatus_nxt;

    // Lowest-index pending line wins: scan downwards so the last hit is the smallest index.
    always_comb begin
        async_cause = '0;
        for (int i = INT_NUM - 1; i >= 0; i--) begin
            if (int_req[i]) async_cause = CAUSE_INT | DW'(16 + i);
        end
    end

    assign async_ev = global_int_en & (|int_req);
    assign event_c  = ID_ecall | ID_ebreak | ID_mret | async_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            trap_q  <= 1'b0;
            cause_q <= '0;
            epc_q   <= '0;
`ifdef CLINT_VECTORED_EN
            async_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (event_c) begin
                        state  <= WRITE;
                        trap_q <= ID_ecall | ID_ebreak | ~ID_mret;
`ifdef CLINT_VECTORED_EN
                        async_q <= ~(ID_ecall | ID_ebreak | ID_mret);
`endif
                        if (ID_ecall) begin
                            cause_q <= CAUSE_ECALL;
                            epc_q   <= ID_pc;
                        end else if (ID_ebreak) begin
                            cause_q <= CAUSE_EBREAK;
                            epc_q   <= ID_pc;
                        end else if (ID_mret) begin
                            cause_q <= '0;
                            epc_q   <= '0;
                        end else begin
                            cause_q <= async_cause;
                            epc_q   <= EX_jump ? EX_jump_addr : ID_pc;
                        end
                    end
                end
                // EX owns the CSR port this cycle; retry the write next cycle.
                WRITE:   if (!EX_csr_we) state <= JUMP;
                JUMP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign trap_base = csr_mtvec & ~DW'(3);

`ifdef CLINT_VECTORED_EN
    assign trap_addr = (async_q && csr_mtvec[0]) ? trap_base + (cause_q << 2) : trap_base;
`else
    assign trap_addr = trap_base;
`endif

    // Trap stacks MIE into MPIE and masks; mret restores MIE and sets MPIE.
    always_comb begin
        mstatus_nxt = csr_mstatus;
        if (trap_q) begin
            mstatus_nxt[7] = csr_mstatus[3];
            mstatus_nxt[3] = 1'b0;
        end else begin
            mstatus_nxt[3] = csr_mstatus[7];
            mstatus_nxt[7] = 1'b1;
        end
    end

    always_comb begin
        int_we        = 3'b000;
        int_mepc      = '0;
        int_mcause    = '0;
        int_mstatus   = '0;
        int_jump      = 1'b0;
        int_jump_addr = '0;
        int_hold      = (state != IDLE) | event_c;
        if (state == WRITE && !EX_csr_we) begin
            int_we      = trap_q ? 3'b111 : 3'b100;
            int_mstatus = mstatus_nxt;
            if (trap_q) begin
                int_mepc   = epc_q;
                int_mcause = cause_q;
            end
        end
        if (state == JUMP) begin
            int_jump      = 1'b1;
            int_jump_addr = trap_q ? trap_addr : csr_mepc;
        end
    end

endmodule
